// File: rtl/timer_share_arbiter_if.sv
// Handshake bundle between requesting control FSMs and the shared
// countdown timer.
interface timer_share_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] load_val;
   logic                  en;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic [NREQ-1:0]       done;
   logic [WIDTH-1:0]      count;

   modport master (
      output req, load_val, en,
      input  grant, busy, done, count
   );

   modport slave (
      input  req, load_val, en,
      output grant, busy, done, count
   );
endinterface

// File: rtl/timer_share_arbiter.sv
// One down-counter time-shared round-robin among NREQ requesters;
// the owner gets a one-cycle done pulse when its countdown expires.
module timer_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   timer_share_arbiter_if.slave  bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DONE
   } state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  cnt, cnt_n;
   logic [NREQ-1:0]   gnt, gnt_n;
   logic [NREQ-1:0]   dn, dn_n;
   logic [PW-1:0]     ptr, ptr_n;
   logic [PW-1:0]     own, own_n;
   logic [PW-1:0]     win;
   logic [PW-1:0]     nxt;
   logic              any;
   logic [WIDTH-1:0]  win_val;
   int unsigned       j;

   // Scan offsets high to low so the closest set bit above ptr wins.
   always_comb begin
      win = ptr;
      any = 1'b0;
      j   = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % NREQ;
         if (bus.req[j]) begin
            win = PW'(j);
            any = 1'b1;
         end
      end
   end

   assign win_val = bus.load_val[int'(win)*WIDTH +: WIDTH];
   assign nxt     = (own == PW'(NREQ - 1)) ? '0 : own + PW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         gnt   <= '0;
         dn    <= '0;
         ptr   <= '0;
         own   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         gnt   <= gnt_n;
         dn    <= dn_n;
         ptr   <= ptr_n;
         own   <= own_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gnt_n   = gnt;
      dn_n    = '0;
      ptr_n   = ptr;
      own_n   = own;
      unique case (state)
         IDLE: begin
            if (any) begin
               state_n    = COUNT;
               gnt_n      = '0;
               gnt_n[win] = 1'b1;
               cnt_n      = win_val;
               own_n      = win;
            end
         end
         COUNT: begin
            if (!bus.req[own]) begin
               state_n = IDLE;
               gnt_n   = '0;
               cnt_n   = '0;
               ptr_n   = nxt;
            end else if (cnt == '0) begin
               state_n   = DONE;
               dn_n[own] = 1'b1;
            end else if (bus.en) begin
               cnt_n = cnt - WIDTH'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
            gnt_n   = '0;
            ptr_n   = nxt;
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
         end
      endcase
   end

   assign bus.grant = gnt;
   assign bus.done  = dn;
   assign bus.count = cnt;
   assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Directed bench for the shared countdown timer arbiter.
module tb_timer_share_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   timer_share_arbiter_if #(.NREQ(4), .WIDTH(4)) bus ();

   timer_share_arbiter #(.NREQ(4), .WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic outs(string tag, logic [3:0] g, logic [3:0] c,
                       logic [3:0] d, logic b);
      chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
      chk({tag, ".count"}, 32'(bus.count), 32'(c));
      chk({tag, ".done"},  32'(bus.done),  32'(d));
      chk({tag, ".busy"},  32'(bus.busy),  32'(b));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      outs("reset", 4'b0000, 4'd0, 4'b0000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_c [9];
      logic [3:0] oh;
      checks       = 0;
      errors       = 0;
      bus.req      = '0;
      bus.load_val = '0;
      bus.en       = 1'b0;
      do_reset();

      // single requester, length 3
      bus.req      = 4'b0001;
      bus.load_val = {4'd0, 4'd0, 4'd0, 4'd3};
      bus.en       = 1'b1;
      step();
      outs("t1.grant", 4'b0001, 4'd3, 4'b0000, 1'b1);
      step(); outs("t1.c2", 4'b0001, 4'd2, 4'b0000, 1'b1);
      step(); outs("t1.c1", 4'b0001, 4'd1, 4'b0000, 1'b1);
      step(); outs("t1.c0", 4'b0001, 4'd0, 4'b0000, 1'b1);
      step(); outs("t1.done", 4'b0001, 4'd0, 4'b0001, 1'b1);
      bus.req = 4'b0000;
      step(); outs("t1.idle", 4'b0000, 4'd0, 4'b0000, 1'b0);

      // round robin among all four
      do_reset();
      bus.req      = 4'b1111;
      bus.load_val = {4'd1, 4'd1, 4'd1, 4'd1};
      bus.en       = 1'b1;
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % 4);
         step(); outs($sformatf("t2.g%0d", k), oh, 4'd1, 4'b0000, 1'b1);
         step(); outs($sformatf("t2.z%0d", k), oh, 4'd0, 4'b0000, 1'b1);
         step(); outs($sformatf("t2.d%0d", k), oh, 4'd0, oh, 1'b1);
         if (k == 4) bus.req = 4'b0000;
         step(); outs($sformatf("t2.i%0d", k), 4'b0000, 4'd0, 4'b0000, 1'b0);
      end

      // enable toggling on requester 2
      do_reset();
      bus.req      = 4'b0100;
      bus.load_val = {4'd0, 4'd5, 4'd0, 4'd0};
      bus.en       = 1'b1;
      step(); outs("t3.grant", 4'b0100, 4'd5, 4'b0000, 1'b1);
      exp_c = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
      for (int k = 0; k < 9; k++) begin
         bus.en = (k % 2 == 0);
         step();
         outs($sformatf("t3.c%0d", k), 4'b0100, exp_c[k], 4'b0000, 1'b1);
      end
      bus.en = 1'b0;
      step(); outs("t3.done", 4'b0100, 4'd0, 4'b0100, 1'b1);
      bus.req = 4'b0000;
      step(); outs("t3.idle", 4'b0000, 4'd0, 4'b0000, 1'b0);

      // zero length on requester 1, no underflow
      bus.req      = 4'b0010;
      bus.load_val = {4'd0, 4'd0, 4'd0, 4'd0};
      bus.en       = 1'b1;
      step(); outs("t4.grant", 4'b0010, 4'd0, 4'b0000, 1'b1);
      step(); outs("t4.done", 4'b0010, 4'd0, 4'b0010, 1'b1);
      bus.req = 4'b0000;
      step(); outs("t4.idle", 4'b0000, 4'd0, 4'b0000, 1'b0);

      // abort by requester 3, pointer moves to 0
      bus.req      = 4'b1001;
      bus.load_val = {4'd9, 4'd0, 4'd0, 4'd1};
      step(); outs("t5.grant", 4'b1000, 4'd9, 4'b0000, 1'b1);
      step(); outs("t5.c8", 4'b1000, 4'd8, 4'b0000, 1'b1);
      step(); outs("t5.c7", 4'b1000, 4'd7, 4'b0000, 1'b1);
      step(); outs("t5.c6", 4'b1000, 4'd6, 4'b0000, 1'b1);
      bus.req = 4'b0001;
      step(); outs("t5.abort", 4'b0000, 4'd0, 4'b0000, 1'b0);
      step(); outs("t5.g0", 4'b0001, 4'd1, 4'b0000, 1'b1);
      step(); outs("t5.z0", 4'b0001, 4'd0, 4'b0000, 1'b1);
      step(); outs("t5.d0", 4'b0001, 4'd0, 4'b0001, 1'b1);
      bus.req = 4'b0000;
      step(); outs("t5.idle", 4'b0000, 4'd0, 4'b0000, 1'b0);

      // asynchronous reset mid-count
      bus.req      = 4'b0100;
      bus.load_val = {4'd0, 4'd4, 4'd1, 4'd1};
      step(); outs("t6.grant", 4'b0100, 4'd4, 4'b0000, 1'b1);
      #2;
      rst     = 1'b1;
      bus.req = 4'b0011;
      #1;
      outs("t6.async", 4'b0000, 4'd0, 4'b0000, 1'b0);
      step(); outs("t6.held", 4'b0000, 4'd0, 4'b0000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(); outs("t6.ptr0", 4'b0001, 4'd1, 4'b0000, 1'b1);
      bus.req = 4'b0000;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
